// File: rtl/mod_inverse_seq.sv
// Sequential modular inverse (binary extended Euclid), one step per clock.
// Optional RUN-cycle watchdog is enabled by defining MODINV_WATCHDOG_EN.
module mod_inverse_seq #(
  parameter int unsigned N = 231
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] p,
  input  logic [N-1:0] a,
  output logic [N-1:0] inv,
  output logic         done,
  output logic         err,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, CHECK, RUN} state_t;

  state_t       state, state_next;
  logic [N-1:0] p_q, a_q, u, v, x1, x2;
  logic [N-1:0] p_next, a_next, u_next, v_next, x1_next, x2_next, inv_next;
  logic         done_next, err_next, busy_next;

`ifdef MODINV_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(4 * N + 4);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(4 * N + 2);
  logic [WD_W-1:0] wd_cnt, wd_cnt_next;
`endif

  // x/2 mod m for odd m; the x+m sum keeps its carry before the shift.
  function automatic logic [N-1:0] halve_mod(input logic [N-1:0] x, input logic [N-1:0] m);
    logic [N:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
    return s[N:1];
  endfunction

  // (x - y) mod m for x, y < m; the wrapped result is always below m.
  function automatic logic [N-1:0] sub_mod(input logic [N-1:0] x, input logic [N-1:0] y,
                                           input logic [N-1:0] m);
    logic [N:0] s;
    s = (x >= y) ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, m} - {1'b0, y});
    return N'(s);
  endfunction

  always_comb begin
    state_next = state;
    p_next     = p_q;
    a_next     = a_q;
    u_next     = u;
    v_next     = v;
    x1_next    = x1;
    x2_next    = x2;
    inv_next   = inv;
    err_next   = err;
    done_next  = 1'b0;
    busy_next  = 1'b0;
`ifdef MODINV_WATCHDOG_EN
    wd_cnt_next = wd_cnt;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          p_next     = p;
          a_next     = a;
          busy_next  = 1'b1;
          state_next = CHECK;
        end
      end
      CHECK: begin
        busy_next = 1'b1;
        if (!p_q[0] || p_q < N'(3) || a_q == '0 || a_q >= p_q) begin
          inv_next   = '0;
          err_next   = 1'b1;
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          u_next     = a_q;
          v_next     = p_q;
          x1_next    = N'(1);
          x2_next    = '0;
          state_next = RUN;
`ifdef MODINV_WATCHDOG_EN
          wd_cnt_next = '0;
`endif
        end
      end
      RUN: begin
        busy_next = 1'b1;
        if (u == N'(1)) begin
          inv_next   = x1;
          err_next   = 1'b0;
          done_next  = 1'b1;
          state_next = IDLE;
        end else if (v == N'(1)) begin
          inv_next   = x2;
          err_next   = 1'b0;
          done_next  = 1'b1;
          state_next = IDLE;
        end else if (u == '0 || v == '0
`ifdef MODINV_WATCHDOG_EN
                     || wd_cnt == WD_LIMIT
`endif
                    ) begin
          inv_next   = '0;
          err_next   = 1'b1;
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
`ifdef MODINV_WATCHDOG_EN
          wd_cnt_next = wd_cnt + 1'b1;
`endif
          if (!u[0]) begin
            u_next  = u >> 1;
            x1_next = halve_mod(x1, p_q);
          end else if (!v[0]) begin
            v_next  = v >> 1;
            x2_next = halve_mod(x2, p_q);
          end else if (u >= v) begin
            u_next  = u - v;
            x1_next = sub_mod(x1, x2, p_q);
          end else begin
            v_next  = v - u;
            x2_next = sub_mod(x2, x1, p_q);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: every register here, datapath included, is cleared by reset and
  // updated only with non-blocking assignments from the comb next-values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      p_q   <= '0;
      a_q   <= '0;
      u     <= '0;
      v     <= '0;
      x1    <= '0;
      x2    <= '0;
      inv   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
`ifdef MODINV_WATCHDOG_EN
      wd_cnt <= '0;
`endif
    end else begin
      state <= state_next;
      p_q   <= p_next;
      a_q   <= a_next;
      u     <= u_next;
      v     <= v_next;
      x1    <= x1_next;
      x2    <= x2_next;
      inv   <= inv_next;
      done  <= done_next;
      err   <= err_next;
      busy  <= busy_next;
`ifdef MODINV_WATCHDOG_EN
      wd_cnt <= wd_cnt_next;
`endif
    end
  end

endmodule

// File: tb/tb_mod_inverse_seq.sv
// Scoreboard bench for mod_inverse_seq: a division-based extended Euclid
// model predicts each result, which is compared when done pulses.
module tb_mod_inverse_seq;

  localparam int N = 231;
  localparam int W = 512;
  localparam int BOUND = 4 * N + 3;
  localparam int SMALL_BOUND = 35;

  typedef struct {
    logic [N-1:0] p;
    logic [N-1:0] a;
    logic [N-1:0] inv;
    logic         err;
    int           start_cyc;
    int           exact_lat;
    int           max_lat;
  } exp_t;

  logic         clk, reset, start;
  logic [N-1:0] p_in, a_in, inv;
  logic         done, err, busy;

  exp_t sb[$];
  exp_t mon_e;
  int   mon_lat;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  mod_inverse_seq #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .p(p_in), .a(a_in),
    .inv(inv), .done(done), .err(err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [N-1:0] p, input logic [N-1:0] a,
                                output logic [N-1:0] inv_o, output logic err_o);
    logic [W-1:0] r0, r1, t0, t1, q, tmp, pw;
    pw = W'(p);
    if (!p[0] || p < N'(3) || a == '0 || a >= p) begin
      inv_o = '0;
      err_o = 1'b1;
      return;
    end
    r0 = pw; r1 = W'(a); t0 = '0; t1 = W'(1);
    while (r1 != '0) begin
      q   = r0 / r1;
      tmp = r0 - q * r1;
      r0  = r1;
      r1  = tmp;
      tmp = (t0 + pw - ((q * t1) % pw)) % pw;
      t0  = t1;
      t1  = tmp;
    end
    if (r0 == W'(1)) begin
      inv_o = N'(t0);
      err_o = 1'b0;
    end else begin
      inv_o = '0;
      err_o = 1'b1;
    end
  endfunction

  // Caller aligns to the cycle in which start is to be high.
  task automatic issue(input logic [N-1:0] p, input logic [N-1:0] a,
                       input int exact_lat, input int max_lat);
    logic [N-1:0] ei;
    logic         ee;
    model(p, a, ei, ee);
    p_in  = p;
    a_in  = a;
    start = 1'b1;
    sb.push_back('{p: p, a: a, inv: ei, err: ee, start_cyc: cyc,
                   exact_lat: exact_lat, max_lat: max_lat});
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit busy_ok);
    bit seen = 1'b0;
    busy_ok = 1'b1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      seen = done;
    end
    check("done_within_budget", W'(seen), W'(1));
  endtask

  // Scoreboard consumer: every done pulse must match the oldest accepted start.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", W'(done), W'(0));
      end else begin
        mon_e   = sb.pop_front();
        mon_lat = cyc - mon_e.start_cyc;
        check("inv", W'(inv), W'(mon_e.inv));
        check("err", W'(err), W'(mon_e.err));
        check("busy_in_done_cycle", W'(busy), W'(1));
        if (mon_e.exact_lat > 0) check("latency", W'(mon_lat), W'(mon_e.exact_lat));
        else check("latency_bound", W'(mon_lat <= mon_e.max_lat), W'(1));
        if (!mon_e.err)
          check("inv_times_a_mod_p", (W'(inv) * W'(mon_e.a)) % W'(mon_e.p), W'(1));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] rp, ra, p224, k224;
    logic [255:0] r;
    bit bok;

    reset = 1'b1; start = 1'b0; p_in = '0; a_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_inv", W'(inv), W'(0));
    check("reset_done", W'(done), W'(0));
    check("reset_err", W'(err), W'(0));
    check("reset_busy", W'(busy), W'(0));
    reset = 1'b0;

    // Basic inverse with busy window.
    @(posedge clk); #1;
    issue(N'(7), N'(3), 0, SMALL_BOUND);
    wait_done(BOUND + 8, bok);
    check("busy_through_done", W'(bok), W'(1));
    @(negedge clk);
    check("busy_after_done", W'(busy), W'(0));

    // a=1 exact latency, a=p-1 boundary.
    @(posedge clk); #1;
    issue(N'(11), N'(1), 3, 0);
    wait_done(BOUND + 8, bok);
    @(posedge clk); #1;
    issue(N'(13), N'(12), 0, SMALL_BOUND);
    wait_done(BOUND + 8, bok);

    // Invalid operands and gcd failure.
    @(posedge clk); #1; issue(N'(8), N'(3), 2, 0); wait_done(BOUND + 8, bok);
    @(posedge clk); #1; issue(N'(9), N'(3), 0, SMALL_BOUND); wait_done(BOUND + 8, bok);
    @(posedge clk); #1; issue(N'(7), N'(7), 2, 0); wait_done(BOUND + 8, bok);
    @(posedge clk); #1; issue(N'(7), N'(0), 2, 0); wait_done(BOUND + 8, bok);
    @(posedge clk); #1; issue(N'(1), N'(0), 2, 0); wait_done(BOUND + 8, bok);

    // Start while busy is ignored; start in the done cycle is accepted.
    @(posedge clk); #1;
    issue(N'(7), N'(3), 0, SMALL_BOUND);
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_in = N'(2); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(BOUND + 8, bok);
    issue(N'(7), N'(2), 0, SMALL_BOUND);
    wait_done(BOUND + 8, bok);

    // Reset mid-run aborts with no done.
    @(posedge clk); #1;
    issue(N'(7), N'(3), 0, SMALL_BOUND);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_inv", W'(inv), W'(0));
    check("abort_done", W'(done), W'(0));
    check("abort_err", W'(err), W'(0));
    check("abort_busy", W'(busy), W'(0));
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("idle_after_abort", W'(busy), W'(0));
    issue(N'(7), N'(3), 0, SMALL_BOUND);
    wait_done(BOUND + 8, bok);

    // Full-width operands, including NIST P-224 and secp224k1 moduli.
    p224 = (N'(1) << 224) - (N'(1) << 96) + N'(1);
    k224 = (N'(1) << 224) - (N'(1) << 32) - N'(6803);
    for (int i = 0; i < 40; i++) begin
      for (int j = 0; j < 8; j++) r[j*32 +: 32] = $urandom;
      case (i % 4)
        0:       rp = p224;
        1:       rp = k224;
        default: rp = N'(r) | N'(1) | (N'(1) << (N - 1));
      endcase
      for (int j = 0; j < 8; j++) r[j*32 +: 32] = $urandom;
      ra = N'(W'(r) % W'(rp));
      if (ra == '0) ra = N'(1);
      @(posedge clk); #1;
      issue(rp, ra, 0, BOUND);
      wait_done(BOUND + 8, bok);
    end

    repeat (4) @(posedge clk);
    check("scoreboard_drained", W'(sb.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
